// File: rtl/zmem_reader_if.sv
// Bundle of control, Z-memory read port and result stream signals for zmem_reader.
// The master modport is the reader; the slave modport is its environment.
interface zmem_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              start_i;
    logic [ADDR_W-1:0] zlen_i;
    logic              zmem_rd_o;
    logic [ADDR_W-1:0] zmem_addr_o;
    logic [DATA_W-1:0] zmem_data_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              busy_o;
    logic              done_o;

    modport master (
        input  start_i, zlen_i, zmem_data_i, ready_i,
        output zmem_rd_o, zmem_addr_o, data_o, valid_o, busy_o, done_o
    );

    modport slave (
        output start_i, zlen_i, zmem_data_i, ready_i,
        input  zmem_rd_o, zmem_addr_o, data_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/zmem_reader.sv
// Streams zlen words out of the Z result memory through a 2-entry FIFO
// with ready/valid backpressure.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing memory reads
// DRAIN | all reads issued, FIFO or in-flight read not yet empty
// DONE  | one cycle, done pulse
module zmem_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input logic          clk,
    input logic          rstn,
    zmem_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] zlen_q;
    logic              inflight_q;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        occ;
    logic              start_acc;
    logic              rd, pop, push, last_rd;
    logic [2:0]        credit;

    assign start_acc = (state == IDLE) && bus.start_i;
    assign push      = inflight_q;
    assign pop       = (occ != 2'd0) && bus.ready_i;
    // Words already owned (buffered or in flight) after this cycle's pop.
    assign credit    = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd        = (state == READ) && (credit < 3'd2);
    assign last_rd   = rd && (addr_q == zlen_q - ADDR_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    state_nxt = (bus.zlen_i == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (last_rd) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (occ == 2'd1) && !inflight_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q     <= '0;
            zlen_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd;
            if (start_acc) begin
                addr_q <= '0;
                zlen_q <= bus.zlen_i;
            end else if (rd) begin
                addr_q <= addr_q + ADDR_W'(1);
            end else if (state == DONE) begin
                addr_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.zmem_data_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.zmem_rd_o   = rd;
    assign bus.zmem_addr_o = addr_q;
    assign bus.valid_o     = (occ != 2'd0);
    assign bus.data_o      = (occ != 2'd0) ? fifo_mem[rd_ptr] : '0;
    assign bus.busy_o      = (state == READ) || (state == DRAIN);
    assign bus.done_o      = (state == DONE);
endmodule

// File: tb/tb_zmem_reader.sv
// Scoreboard bench for zmem_reader: expected words are queued at start,
// a negedge monitor checks reads, stream words, stalls and done pulses.
module tb_zmem_reader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    zmem_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    zmem_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data = addr + 100, one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.zmem_rd_o) bus.zmem_data_i <= DATA_W'(bus.zmem_addr_o) + 16'd100;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [DATA_W-1:0] exp_q[$];
    int exp_addr = 0, run_len = 0, rd_cnt = 0, pop_cnt = 0, done_cnt = 0;
    int first_rd = -1, first_val = -1, last_rd_c = -1, done_cyc = -1, t_start = 0;
    bit busy_seen = 0;
    bit prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rstn) begin
            if (prev_stall) begin
                check("hold_valid", bus.valid_o, 1);
                check("hold_data", bus.data_o, prev_data);
            end
            if (bus.zmem_rd_o) begin
                check("rd_addr", bus.zmem_addr_o, exp_addr);
                check("rd_in_range", int'(bus.zmem_addr_o) < run_len, 1);
                check("outstanding_le2", (rd_cnt - pop_cnt) <= 2, 1);
                if (first_rd < 0) first_rd = cyc;
                last_rd_c = cyc;
                exp_addr++;
                rd_cnt++;
            end
            if (bus.busy_o) busy_seen = 1;
            if (bus.valid_o && bus.ready_i) begin
                if (first_val < 0) first_val = cyc;
                if (exp_q.size() == 0) check("extra_word_queue_size", exp_q.size(), 1);
                else check("data", bus.data_o, exp_q.pop_front());
                pop_cnt++;
            end
            if (bus.done_o) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", bus.busy_o, 0);
                check("queue_empty_at_done", exp_q.size(), 0);
            end
            prev_stall = bus.valid_o && !bus.ready_i;
            prev_data  = bus.data_o;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic start_run(input int len);
        @(posedge clk); #1;
        exp_addr  = 0;
        run_len   = len;
        rd_cnt    = 0;
        pop_cnt   = 0;
        first_rd  = -1;
        first_val = -1;
        last_rd_c = -1;
        busy_seen = 0;
        for (int i = 0; i < len; i++) exp_q.push_back(DATA_W'(100 + i));
        bus.start_i = 1'b1;
        bus.zlen_i  = ADDR_W'(len);
        t_start     = cyc;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.zlen_i  = ADDR_W'(len ^ 5);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int d0 = done_cnt;
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd) bus.ready_i = 1'($urandom_range(0, 1));
            if (done_cnt > d0) begin
                ok = 1;
                break;
            end
        end
        bus.ready_i = 1'b1;
        check("done_within_budget", ok, 1);
    endtask

    task automatic wait_pops(input int n, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (pop_cnt >= n) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("pops_within_budget", ok, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},    bus.zmem_rd_o, 0);
        check({tag, "_addr"},  bus.zmem_addr_o, 0);
        check({tag, "_data"},  bus.data_o, 0);
        check({tag, "_valid"}, bus.valid_o, 0);
        check({tag, "_busy"},  bus.busy_o, 0);
        check({tag, "_done"},  bus.done_o, 0);
    endtask

    initial begin
        int d0;
        bus.start_i = 1'b0;
        bus.zlen_i  = '0;
        bus.ready_i = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // zlen=5, ready high: cycle-exact timing
        start_run(5);
        wait_done(50, 0);
        check("a_first_rd", first_rd, t_start + 1);
        check("a_last_rd", last_rd_c, t_start + 5);
        check("a_rd_cnt", rd_cnt, 5);
        check("a_first_valid", first_val, t_start + 3);
        check("a_done_cycle", done_cyc, t_start + 8);
        check("a_words", pop_cnt, 5);

        // zlen=0: immediate done, no reads, never busy
        start_run(0);
        wait_done(20, 0);
        check("b_done_cycle", done_cyc, t_start + 1);
        check("b_rd_cnt", rd_cnt, 0);
        check("b_busy_seen", busy_seen, 0);

        // zlen=8 with a 4-cycle ready drop after the 2nd word
        start_run(8);
        wait_pops(2, 50);
        bus.ready_i = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("c_stall_outstanding", rd_cnt - pop_cnt, 2);
        bus.ready_i = 1'b1;
        wait_done(50, 0);
        check("c_words", pop_cnt, 8);
        check("c_rd_cnt", rd_cnt, 8);

        // zlen=6 with an ignored start pulse mid-readout
        d0 = done_cnt;
        start_run(6);
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.start_i = 1'b1;
        bus.zlen_i  = ADDR_W'(3);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_done(50, 0);
        repeat (10) @(posedge clk);
        #1;
        check("d_done_pulses", done_cnt - d0, 1);
        check("d_words", pop_cnt, 6);
        check("d_rd_cnt", rd_cnt, 6);

        // zlen=10, reset after the 3rd word, then a fresh zlen=2 run
        start_run(10);
        wait_pops(3, 50);
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        d0 = done_cnt;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("e_no_done_after_reset", done_cnt - d0, 0);
        start_run(2);
        wait_done(30, 0);
        check("e_rd_cnt", rd_cnt, 2);
        check("e_words", pop_cnt, 2);
        check("e_first_valid", first_val, t_start + 3);

        // zlen=63 with random ready: full range, no wrap
        start_run(63);
        wait_done(1000, 1);
        check("f_rd_cnt", rd_cnt, 63);
        check("f_next_addr", exp_addr, 63);
        check("f_words", pop_cnt, 63);
        repeat (5) @(posedge clk);
        #1;
        check("f_idle_busy", bus.busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/zmem_reader.md
ZMEM_READER -- requirements
Module: zmem_reader

Interface
- REQ-001: Parameter DATA_W, default 16, width of one result word.
- REQ-002: Parameter ADDR_W, default 6, width of the Z-memory address and the length field.
- REQ-003: The block SHALL have one clock; reset is asynchronous and active-low (ports clk, rstn).
- REQ-004: clk  input  1  rising-edge clock for all state.
- REQ-005: rstn  input  1  asynchronous active-low reset.
- REQ-006: start_i  input  1  single-cycle request to begin readout of the Z result memory.
- REQ-007: zlen_i  input  ADDR_W  number of Z entries to read; sampled only when start is accepted.
- REQ-008: zmem_rd_o  output  1  read strobe to the Z memory.
- REQ-009: zmem_addr_o  output  ADDR_W  Z index being read.
- REQ-010: zmem_data_i  input  DATA_W  read data, valid exactly one cycle after zmem_rd_o.
- REQ-011: data_o  output  DATA_W  streamed result word.
- REQ-012: valid_o  output  1  data_o holds a valid word.
- REQ-013: ready_i  input  1  downstream accepts data_o when valid_o and ready_i are both high.
- REQ-014: busy_o  output  1  readout in progress.
- REQ-015: done_o  output  1  one-cycle pulse at the end of a readout.

Function
- REQ-016: FSM states: IDLE, READ (issuing reads), DRAIN (all reads issued, buffer not empty), DONE (one cycle, done_o=1).
- REQ-017: IDLE->READ when start_i=1 and zlen_i!=0; IDLE->DONE when start_i=1 and zlen_i=0; DONE->IDLE unconditionally.
- REQ-018: start_i SHALL be ignored in every state except IDLE; zlen_i changes after acceptance have no effect.
- REQ-019: An issue counter SHALL start at 0, present its value on zmem_addr_o, and increment by 1 per cycle with zmem_rd_o=1.
- REQ-020: zmem_rd_o SHALL first assert in the cycle after start is accepted, with address 0.
- REQ-021: READ->DRAIN in the cycle after the read of address zlen-1 is issued; no address >= zlen is ever read, and the counter never wraps.
- REQ-022: Returned words SHALL be written into a 2-entry FIFO the cycle zmem_data_i is valid and appear on data_o/valid_o the following cycle, in address order.
- REQ-023: A read SHALL be issued only if (FIFO occupancy + reads in flight - pop this cycle) < 2, so the FIFO never overflows and no word is dropped under any ready_i pattern.
- REQ-024: With ready_i held high, throughput SHALL be one word per cycle; start in cycle T gives the first valid_o in T+3.
- REQ-025: data_o and valid_o SHALL remain stable while valid_o=1 and ready_i=0.
- REQ-026: DRAIN->DONE in the cycle after the handshake of the last word; done_o=1 for exactly that one cycle.
- REQ-027: busy_o SHALL be 1 in READ and DRAIN only, and 0 in IDLE and DONE.

Reset
- REQ-028: While rstn=0, the block SHALL be in IDLE with zmem_rd_o, zmem_addr_o, data_o, valid_o, busy_o and done_o all 0, the FIFO empty, and the counters cleared.
- REQ-029: Reset asserted mid-readout SHALL abandon the transfer with no done_o pulse; the next accepted start restarts at address 0.

Verification
- REQ-030: Set zlen=5, ready_i=1, memory model data=addr+100, start at T -> reads of addresses 0..4 in T+1..T+5; data_o 100..104 in T+3..T+7; done_o at T+8 only.
- REQ-031: Set zlen=0, start at T -> no zmem_rd_o; done_o=1 at T+1; busy_o stays 0.
- REQ-032: Set zlen=8 and drop ready_i for 4 cycles after the 2nd word -> zmem_rd_o stalls with at most 2 words buffered or in flight; data_o shows 100..107 exactly once each, in order.
- REQ-033: Pulse start_i with zlen=3 during an active zlen=6 readout -> the pulse is ignored; exactly 6 words are delivered and one done_o is seen.
- REQ-034: Assert rstn low after the 3rd word of a zlen=10 readout -> all outputs go to 0 at once with no done_o; a new start with zlen=2 reads addresses 0..1 and delivers 100 and 101.
- REQ-035: Set zlen=63 with random ready_i -> addresses 0..62 are each read exactly once, 63 words arrive in order, and no wrap occurs.
